vc_input_port: RTL
==================

# vc_input_port

Per-input-port buffering stage for the next-generation router: replaces single-queue input buffering with V independent virtual-channel FIFOs of depth B each, plus per-VC credit return and a round-robin VC arbiter. Each instance serves one router input. It offers one head flit per cycle to the switch allocator and sends it to the crossbar on grant. Packets are single-flit. Routing is lookahead: the upstream node writes the one-hot output-port vector into the flit's low P bits.

## Interface
- FW, 36, flit width in bits; bits [P-1:0] hold the one-hot destination output port
- P, 7, number of router ports
- V, 2, number of virtual channels, 1..8
- B, 4, depth of each VC FIFO, power of two, at least 2
- VW, derived, max(1, clog2(V)), VC index width
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- flit_in_wr  input  1  write strobe for flit_in
- flit_in  input  FW  incoming flit
- flit_in_vc  input  VW  target VC of the incoming flit
- credit_out  output  V  one-cycle pulse per VC when a slot of that VC is freed
- dest_port_req  output  P  one-hot request to the switch allocator; all zero when idle
- outport_available  input  P  per-output availability (downstream credit present)
- grant  input  1  allocator grant for this port's current request
- flit_to_crossbar  output  FW  selected head flit; valid while dest_port_req is nonzero
- flit_to_crossbar_vc  output  VW  VC index of flit_to_crossbar
- overflow_err  output  1  sticky overflow flag; present only with VC_PORT_ERRCHK_EN

## Operation
- Each VC has its own FIFO with write pointer, read pointer (log2 B bits, natural wrap) and a count (clog2(B+1) bits).
- Write: when flit_in_wr is high, flit_in is stored in FIFO[flit_in_vc] at the clock edge.
- A write to a full VC is accepted only if the same VC is popped in the same cycle. Otherwise the flit is dropped.
- A flit_in_vc value of V or more is ignored.
- Eligible VC: FIFO non-empty, and (head[P-1:0] & outport_available) is nonzero.
- Arbiter: round-robin over eligible VCs. The search starts at a registered pointer rr_ptr.
- Output selection is combinational from FIFO heads, rr_ptr and outport_available:
  - dest_port_req = head[P-1:0] of the selected VC
  - flit_to_crossbar = head flit of the selected VC
  - flit_to_crossbar_vc = selected VC index
- If no VC is eligible, dest_port_req is 0 and the flit outputs hold their previous value. That value is don't-care.
- Grant while dest_port_req is nonzero:
  - the selected VC pops at the edge
  - rr_ptr becomes (selected + 1) mod V
  - credit_out[selected] pulses high for the following cycle
- Grant while dest_port_req is 0 is ignored.
- rr_ptr does not move without a grant.
- With V = 1 the arbiter degenerates to a single queue. rr_ptr is held at 0.

## Timing
- Write-to-request latency is one cycle: a flit written at edge n may request in cycle n+1.
- Request-to-crossbar latency is zero: flit_to_crossbar is valid in the same cycle as dest_port_req.
- Grant-to-credit latency is one cycle. Credit pulses are registered outputs.
- Push and pop on the same VC in the same cycle leave the count unchanged.
- On reset, all of the following clear immediately and asynchronously:
  - counts and pointers = 0
  - rr_ptr = 0
  - credit_out = 0
  - dest_port_req = 0
  - flit_to_crossbar = 0
  - flit_to_crossbar_vc = 0
  - overflow_err = 0
- Reset mid-operation discards all buffered flits. No credit is returned for them; upstream counters reset together with this block.
- FIFO storage is not reset.

## Configuration
- VC_PORT_ERRCHK_EN defined:
  - an overflow_err port is added
  - it is set at the edge where a flit is dropped because its VC is full with no simultaneous pop
  - it is also set for an out-of-range flit_in_vc
  - it stays high until reset
- Not defined: the port is absent; drops are silent and there is no other logic difference.

## Test plan
- Reset, V=2, B=4: write a flit with dest 7'b0000100 to VC1, outport_available=all ones. Next cycle dest_port_req=0000100 and flit_to_crossbar_vc=1. Assert grant: the following cycle credit_out=2'b10 for one cycle, and dest_port_req returns to 0.
- Fill VC0 with 4 flits with no grant, then a 5th write to VC0: the flit is dropped and overflow_err=1 (macro on). Drain 4 grants: exactly 4 credit_out[0] pulses, in original order.
- VC0 and VC1 both non-empty, grant every cycle: selection alternates 0,1,0,1 starting from VC0 after reset.
- VC0 head dest=port 3 with outport_available[3]=0, VC1 head dest=port 5 available: VC1 is requested and granted; VC0 is requested once bit 3 rises.
- VC0 full (4 flits): push to VC0 and grant VC0 in the same cycle. The push is accepted, count stays 4, overflow_err stays 0.
- Assert rst_n=0 mid-traffic with 3 flits buffered: outputs are 0 immediately. After release, dest_port_req stays 0 until a new write arrives.

Source files
------------

// File: rtl/vc_input_port.sv
// Router input port: V virtual-channel FIFOs of depth B, a round-robin VC arbiter, and per-VC credit return.
// Optional feature macro: VC_PORT_ERRCHK_EN adds a sticky overflow_err output.
module vc_input_port #(
  parameter int FW = 36,
  parameter int P  = 7,
  parameter int V  = 2,
  parameter int B  = 4,
  parameter int VW = (V > 1) ? $clog2(V) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flit_in_wr,
  input  logic [FW-1:0] flit_in,
  input  logic [VW-1:0] flit_in_vc,
  output logic [V-1:0]  credit_out,
  output logic [P-1:0]  dest_port_req,
  input  logic [P-1:0]  outport_available,
  input  logic          grant,
  output logic [FW-1:0] flit_to_crossbar,
  output logic [VW-1:0] flit_to_crossbar_vc
`ifdef VC_PORT_ERRCHK_EN
  ,
  output logic          overflow_err
`endif
);

  localparam int PW = $clog2(B);
  localparam int CW = $clog2(B + 1);

  logic [FW-1:0] mem    [V][B];
  logic [PW-1:0] wr_ptr [V];
  logic [PW-1:0] rd_ptr [V];
  logic [CW-1:0] count  [V];
  logic [VW-1:0] rr_ptr;

  logic [FW-1:0] head [V];
  logic [V-1:0]  eligible;
  logic          sel_valid;
  logic [VW-1:0] sel_vc;
  logic [VW-1:0] rr_next;
  logic [FW-1:0] hold_flit;
  logic [VW-1:0] hold_vc;
  logic          pop;
  logic [V-1:0]  pop_vec;
  logic [V-1:0]  push_vec;
  logic          in_range;

  always_comb begin
    for (int v = 0; v < V; v++) begin
      head[v]     = mem[v][rd_ptr[v]];
      eligible[v] = (count[v] != '0) && ((head[v][P-1:0] & outport_available) != '0);
    end
  end

  // Round-robin search: first eligible VC at or after rr_ptr, wrapping modulo V.
  always_comb begin
    int idx;
    sel_valid = 1'b0;
    sel_vc    = '0;
    idx       = 0;
    for (int i = 0; i < V; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= V) idx = idx - V;
      if (!sel_valid && eligible[idx]) begin
        sel_valid = 1'b1;
        sel_vc    = VW'(idx);
      end
    end
  end

  // Flit outputs fall back to the last offered flit when nothing is eligible.
  assign dest_port_req       = sel_valid ? head[sel_vc][P-1:0] : '0;
  assign flit_to_crossbar    = sel_valid ? head[sel_vc] : hold_flit;
  assign flit_to_crossbar_vc = sel_valid ? sel_vc : hold_vc;

  assign pop      = grant && sel_valid;
  assign in_range = int'(flit_in_vc) < V;
  assign rr_next  = (int'(sel_vc) + 1 >= V) ? '0 : sel_vc + VW'(1);

  // A full VC still accepts a write when the same VC is popped on this edge.
  always_comb begin
    for (int v = 0; v < V; v++) begin
      pop_vec[v]  = pop && (sel_vc == VW'(v));
      push_vec[v] = flit_in_wr && in_range && (flit_in_vc == VW'(v)) &&
                    ((count[v] != CW'(B)) || pop_vec[v]);
    end
  end

  // NOTE: flit storage carries no reset; occupancy is tracked by count, so stale data is never offered.
  always_ff @(posedge clk) begin
    for (int v = 0; v < V; v++) begin
      if (push_vec[v]) mem[v][wr_ptr[v]] <= flit_in;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < V; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        count[v]  <= '0;
      end
      rr_ptr     <= '0;
      credit_out <= '0;
      hold_flit  <= '0;
      hold_vc    <= '0;
    end else begin
      for (int v = 0; v < V; v++) begin
        if (push_vec[v]) wr_ptr[v] <= wr_ptr[v] + PW'(1);
        if (pop_vec[v])  rd_ptr[v] <= rd_ptr[v] + PW'(1);
        if (push_vec[v] && !pop_vec[v])      count[v] <= count[v] + CW'(1);
        else if (pop_vec[v] && !push_vec[v]) count[v] <= count[v] - CW'(1);
      end
      credit_out <= pop_vec;
      if (pop) rr_ptr <= rr_next;
      if (sel_valid) begin
        hold_flit <= head[sel_vc];
        hold_vc   <= sel_vc;
      end
    end
  end

`ifdef VC_PORT_ERRCHK_EN
  logic [V-1:0] full_drop;
  logic         drop;

  always_comb begin
    for (int v = 0; v < V; v++) begin
      full_drop[v] = (flit_in_vc == VW'(v)) && (count[v] == CW'(B)) && !pop_vec[v];
    end
  end

  assign drop = flit_in_wr && (!in_range || (full_drop != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    overflow_err <= 1'b0;
    else if (drop) overflow_err <= 1'b1;
  end
`endif

endmodule
